// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - shared types for the series evaluation controller
//
// Purpose: state encoding, mode bit positions and the strobe bundle used by
// series_eval_controller and its divisor counter.
package series_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_REL,
    S_INIT,
    S_MULX1,
    S_MULX2,
    S_DIVI,
    S_DIVIP1,
    S_NEG,
    S_ACC,
    S_CHECK
  } state_t;

  // Bit positions inside the 2-bit mode word.
  localparam int MODE_STEP1 = 0;  // 1: one x multiply and one divide per term
  localparam int MODE_ALT   = 1;  // 1: negate every term

  // Every Moore output of the controller except ready.
  typedef struct packed {
    logic ldx;
    logic ldy;
    logic init_term;
    logic init_exp;
    logic x_en;
    logic ldterm;
    logic i_en;
    logic iplus_en;
    logic minus1_en;
    logic ldexp;
  } strobes_t;

  localparam strobes_t STROBES_NONE = '0;

endpackage

// File: rtl/series_div_counter.sv
// rtl/series_div_counter.sv - loadable divisor pair counter
//
// Purpose: holds the two divisors (i, i+1) used by the divide steps of one term.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          load the first divisor pair for the selected step size
//   advance       move both divisors forward by one term
//   step1         1: step-1 series (advance by 1), 0: step-2 series (advance by 2)
//   div_i         first divisor
//   div_ip1       second divisor (div_i + 1)
module series_div_counter #(
  parameter int CNT_W    = 5,
  parameter int I0_STEP1 = 1,
  parameter int I0_STEP2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             step1,
  output logic [CNT_W-1:0] div_i,
  output logic [CNT_W-1:0] div_ip1
);

  localparam logic [CNT_W-1:0] I0_S1   = CNT_W'(I0_STEP1);
  localparam logic [CNT_W-1:0] I0_S1P1 = CNT_W'(I0_STEP1 + 1);
  localparam logic [CNT_W-1:0] I0_S2   = CNT_W'(I0_STEP2);
  localparam logic [CNT_W-1:0] I0_S2P1 = CNT_W'(I0_STEP2 + 1);

  logic [CNT_W-1:0] inc;

  assign inc = step1 ? CNT_W'(1) : CNT_W'(2);

  // Reset value matches the step-2 mode the controller latches on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_i   <= I0_S2;
      div_ip1 <= I0_S2P1;
    end else if (load) begin
      div_i   <= step1 ? I0_S1   : I0_S2;
      div_ip1 <= step1 ? I0_S1P1 : I0_S2P1;
    end else if (advance) begin
      div_i   <= div_i + inc;
      div_ip1 <= div_ip1 + inc;
    end
  end

endmodule

// File: rtl/series_eval_controller.sv
// rtl/series_eval_controller.sv - FSM sequencing a Taylor-series datapath
//
// Purpose: one start/ready transaction runs one series evaluation on the shared
// multiply/divide/accumulate datapath. Supports step-1 or step-2 power series,
// optional alternating sign, |term| < y convergence and a MAX_TERMS cap.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           request; evaluation launches when start is released
//   mode[1:0]       [0] step-1 series, [1] alternate sign; latched with start
//   y               unsigned convergence threshold, sampled in INIT
//   term            signed current term from the datapath, used in CHECK
//   ready           controller idle, result valid
//   ovf             last evaluation hit MAX_TERMS without converging
//   ldx, ldy, init_term, init_exp           INIT-cycle loads
//   x_en, ldterm, i_en, iplus_en, minus1_en, ldexp   datapath strobes
//   div_i, div_ip1  current divisor pair
module series_eval_controller
  import series_pkg::*;
#(
  parameter int DATA_W    = 17,
  parameter int Y_W       = 8,
  parameter int CNT_W     = 5,
  parameter int MAX_TERMS = 12,
  parameter int I0_STEP1  = 1,
  parameter int I0_STEP2  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [Y_W-1:0]           y,
  input  logic signed [DATA_W-1:0] term,
  output logic                     ready,
  output logic                     ovf,
  output logic                     ldx,
  output logic                     ldy,
  output logic                     init_term,
  output logic                     init_exp,
  output logic                     x_en,
  output logic                     ldterm,
  output logic                     i_en,
  output logic                     iplus_en,
  output logic                     minus1_en,
  output logic                     ldexp,
  output logic [CNT_W-1:0]         div_i,
  output logic [CNT_W-1:0]         div_ip1
);

  localparam int NT_W = $clog2(MAX_TERMS + 1);

  localparam logic [DATA_W-1:0] TERM_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] TERM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [NT_W-1:0]   NT_CAP   = NT_W'(MAX_TERMS);

  state_t          state, state_nx;
  logic [NT_W-1:0] nterm;
  logic            ovf_q;
  logic [1:0]      mode_q;
  logic [Y_W-1:0]  y_q;
  strobes_t        stb;

  logic [DATA_W-1:0] abs_term;
  logic [DATA_W-1:0] y_ext;
  logic              above_y;
  logic              at_cap;
  logic              step1;
  logic              alt;

  assign step1 = mode_q[MODE_STEP1];
  assign alt   = mode_q[MODE_ALT];

  // |term| in DATA_W bits; the most negative value has no positive twin and
  // saturates so it is still treated as a large term.
  always_comb begin
    abs_term = term;
    if (term == TERM_MIN) begin
      abs_term = TERM_MAX;
    end else if (term[DATA_W-1]) begin
      abs_term = -term;
    end
  end

  assign y_ext   = {{(DATA_W-Y_W){1'b0}}, y_q};
  assign above_y = (abs_term >= y_ext);
  assign at_cap  = (nterm == NT_CAP);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Evaluation bookkeeping: latched mode/threshold, term count, overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      nterm  <= '0;
      ovf_q  <= 1'b0;
      mode_q <= 2'b00;
      y_q    <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mode_q <= mode;
      end
      if (state == S_INIT) begin
        nterm <= '0;
        ovf_q <= 1'b0;
        y_q   <= y;
      end
      if (state == S_ACC) begin
        nterm <= nterm + NT_W'(1);
      end
      // Convergence wins over the cap, so overflow needs |term| still >= y.
      if (state == S_CHECK && above_y && at_cap) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_WAIT_REL;
      S_WAIT_REL: if (!start) state_nx = S_INIT;
      S_INIT:     state_nx = S_MULX1;
      S_MULX1:    state_nx = step1 ? S_DIVI : S_MULX2;
      S_MULX2:    state_nx = S_DIVI;
      S_DIVI: begin
        if (!step1)   state_nx = S_DIVIP1;
        else if (alt) state_nx = S_NEG;
        else          state_nx = S_ACC;
      end
      S_DIVIP1:   state_nx = alt ? S_NEG : S_ACC;
      S_NEG:      state_nx = S_ACC;
      S_ACC:      state_nx = S_CHECK;
      S_CHECK: begin
        if (!above_y)    state_nx = S_IDLE;
        else if (at_cap) state_nx = S_IDLE;
        else             state_nx = S_MULX1;
      end
      default:    state_nx = S_IDLE;
    endcase
  end

  // Moore output decode.
  always_comb begin
    stb   = STROBES_NONE;
    ready = 1'b0;
    case (state)
      S_IDLE: ready = 1'b1;
      S_INIT: begin
        stb.ldx       = 1'b1;
        stb.ldy       = 1'b1;
        stb.init_term = 1'b1;
        stb.init_exp  = 1'b1;
      end
      S_MULX1, S_MULX2: begin
        stb.x_en   = 1'b1;
        stb.ldterm = 1'b1;
      end
      S_DIVI: begin
        stb.i_en   = 1'b1;
        stb.ldterm = 1'b1;
      end
      S_DIVIP1: begin
        stb.iplus_en = 1'b1;
        stb.ldterm   = 1'b1;
      end
      S_NEG: begin
        stb.minus1_en = 1'b1;
        stb.ldterm    = 1'b1;
      end
      S_ACC: stb.ldexp = 1'b1;
      default: ;
    endcase
  end

  assign ovf       = ovf_q;
  assign ldx       = stb.ldx;
  assign ldy       = stb.ldy;
  assign init_term = stb.init_term;
  assign init_exp  = stb.init_exp;
  assign x_en      = stb.x_en;
  assign ldterm    = stb.ldterm;
  assign i_en      = stb.i_en;
  assign iplus_en  = stb.iplus_en;
  assign minus1_en = stb.minus1_en;
  assign ldexp     = stb.ldexp;

  series_div_counter #(
    .CNT_W    (CNT_W),
    .I0_STEP1 (I0_STEP1),
    .I0_STEP2 (I0_STEP2)
  ) u_div_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_INIT),
    .advance (state == S_ACC),
    .step1   (step1),
    .div_i   (div_i),
    .div_ip1 (div_ip1)
  );

endmodule

// File: tb/tb_series_eval_controller.sv
// tb/tb_series_eval_controller.sv - directed self-checking bench for series_eval_controller
module tb_series_eval_controller;

  logic               clk;
  logic               rst;
  logic               start;
  logic [1:0]         mode;
  logic [7:0]         y;
  logic signed [16:0] term;
  logic               ready, ovf;
  logic               ldx, ldy, init_term, init_exp;
  logic               x_en, ldterm, i_en, iplus_en, minus1_en, ldexp;
  logic [4:0]         div_i, div_ip1;

  int total = 0;
  int bad   = 0;

  logic signed [16:0] term_vec [0:15];
  int                 nt;
  string              tr;
  int                 div_log[$];
  int                 div_first;
  int                 ovf_wait;
  int                 ovf_end;
  int                 timeout;
  int                 strobe_err;
  int                 hold_bad;

  series_eval_controller #(
    .DATA_W(17), .Y_W(8), .CNT_W(5), .MAX_TERMS(12), .I0_STEP1(1), .I0_STEP2(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .y(y), .term(term),
    .ready(ready), .ovf(ovf),
    .ldx(ldx), .ldy(ldy), .init_term(init_term), .init_exp(init_exp),
    .x_en(x_en), .ldterm(ldterm), .i_en(i_en), .iplus_en(iplus_en),
    .minus1_en(minus1_en), .ldexp(ldexp),
    .div_i(div_i), .div_ip1(div_ip1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divisors must never wrap within an evaluation.
  always @(negedge clk) begin
    if (!rst && ldexp) begin
      total++;
      if (div_ip1 > 5'd29) begin
        bad++;
        $display("FAIL div_wrap: div_ip1=%0d before advance, must be <= 29", div_ip1);
      end
    end
  end

  // Drives one evaluation and records one trace character per cycle from INIT
  // until ready returns: L=init loads, X/I/P/N=datapath strobe, A=ldexp, -=none.
  task automatic run_eval(input logic [1:0] md, input logic [1:0] md_late,
                          input logic [7:0] yv, input int hold, input bit pulse_mx);
    int  k;
    int  cyc;
    int  nstb;
    bit  prev_acc;
    bit  pulsed;
    tr = ""; div_log.delete(); div_first = -1; timeout = 0;
    strobe_err = 0; hold_bad = 0; k = 0; cyc = 0; prev_acc = 0; pulsed = 0;
    @(negedge clk);
    mode = md; y = yv; start = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (ready || ldx) hold_bad++;
    end
    ovf_wait = int'(ovf);
    mode = md_late;
    start = 1'b0;
    while (1) begin
      @(negedge clk);
      if (start) start = 1'b0;
      if (ready) break;
      cyc++;
      if (cyc > 400) begin
        timeout = 1;
        break;
      end
      nstb = int'(x_en) + int'(i_en) + int'(iplus_en) + int'(minus1_en);
      if (nstb > 1 || ldterm != (nstb == 1)) strobe_err++;
      if (ldy != ldx || init_term != ldx || init_exp != ldx) strobe_err++;
      if (ldx)            tr = {tr, "L"};
      else if (x_en)      tr = {tr, "X"};
      else if (i_en)      tr = {tr, "I"};
      else if (iplus_en)  tr = {tr, "P"};
      else if (minus1_en) tr = {tr, "N"};
      else if (ldexp)     tr = {tr, "A"};
      else                tr = {tr, "-"};
      if (tr.len() == 2) div_first = int'(div_i);
      if (prev_acc) div_log.push_back(int'(div_i));
      prev_acc = ldexp;
      if (ldexp) begin
        term = term_vec[(k < nt) ? k : nt - 1];
        k++;
      end
      if (pulse_mx && x_en && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end
    end
    ovf_end = int'(ovf);
  endtask

  task automatic test_reset;
    logic [9:0] s;
    rst = 1'b1; start = 1'b0; mode = 2'b00; y = 8'd0; term = '0;
    repeat (3) @(negedge clk);
    s = {ldx, ldy, init_term, init_exp, x_en, ldterm, i_en, iplus_en, minus1_en, ldexp};
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready); end
    total++; if (s !== 10'b0) begin bad++; $display("FAIL reset_strobes: got %b want 0", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    total++; if (div_i !== 5'd2 || div_ip1 !== 5'd3) begin
      bad++; $display("FAIL reset_div: got %0d/%0d want 2/3", div_i, div_ip1);
    end
    rst = 1'b0;
  endtask

  task automatic test_step2;
    term_vec[0] = 17'sd100; term_vec[1] = 17'sd40; term_vec[2] = 17'sd5; nt = 3;
    run_eval(2'b00, 2'b00, 8'd8, 1, 0);
    total++; if (timeout != 0) begin bad++; $display("FAIL step2_timeout: ready not seen in 400 cycles"); end
    total++; if (tr != "LXXIPA-XXIPA-XXIPA-") begin
      bad++; $display("FAIL step2_trace: got %s want LXXIPA-XXIPA-XXIPA-", tr);
    end
    total++; if (strobe_err != 0) begin bad++; $display("FAIL step2_onehot: got %0d errors want 0", strobe_err); end
    total++; if (div_first != 2) begin bad++; $display("FAIL step2_div_first: got %0d want 2", div_first); end
    total++; if (div_log.size() != 3 || div_log[0] != 4 || div_log[1] != 6 || div_log[2] != 8) begin
      bad++; $display("FAIL step2_div_seq: got %p want 4 6 8", div_log);
    end
    total++; if (div_ip1 !== 5'd9) begin bad++; $display("FAIL step2_div_ip1: got %0d want 9", div_ip1); end
    total++; if (ovf_end != 0) begin bad++; $display("FAIL step2_ovf: got %0d want 0", ovf_end); end
  endtask

  task automatic test_alt_step1;
    term_vec[0] = -17'sd50; term_vec[1] = 17'sd20; term_vec[2] = -17'sd2; nt = 3;
    run_eval(2'b11, 2'b11, 8'd3, 1, 0);
    total++; if (tr != "LXINA-XINA-XINA-") begin
      bad++; $display("FAIL alt_trace: got %s want LXINA-XINA-XINA-", tr);
    end
    total++; if (strobe_err != 0) begin bad++; $display("FAIL alt_onehot: got %0d errors want 0", strobe_err); end
    total++; if (div_first != 1) begin bad++; $display("FAIL alt_div_first: got %0d want 1", div_first); end
    total++; if (div_log.size() != 3 || div_log[0] != 2 || div_log[1] != 3 || div_log[2] != 4) begin
      bad++; $display("FAIL alt_div_seq: got %p want 2 3 4", div_log);
    end
    total++; if (div_ip1 !== 5'd5) begin bad++; $display("FAIL alt_div_ip1: got %0d want 5", div_ip1); end
    total++; if (ovf_end != 0) begin bad++; $display("FAIL alt_ovf: got %0d want 0", ovf_end); end
  endtask

  task automatic test_overflow;
    int acc;
    term_vec[0] = 17'sd500; nt = 1;
    run_eval(2'b00, 2'b00, 8'd1, 1, 0);
    acc = 0;
    for (int i = 0; i < tr.len(); i++) if (tr[i] == "A") acc++;
    total++; if (timeout != 0) begin bad++; $display("FAIL ovf_timeout: ready not seen in 400 cycles"); end
    total++; if (acc != 12) begin bad++; $display("FAIL ovf_acc_count: got %0d want 12", acc); end
    total++; if (tr.len() != 73) begin bad++; $display("FAIL ovf_trace_len: got %0d want 73", tr.len()); end
    total++; if (ovf_end != 1) begin bad++; $display("FAIL ovf_flag: got %0d want 1", ovf_end); end
    total++; if (div_i !== 5'd26) begin bad++; $display("FAIL ovf_div_i: got %0d want 26", div_i); end
  endtask

  task automatic test_min_neg;
    term_vec[0] = -17'sd65536; term_vec[1] = 17'sd0; nt = 2;
    run_eval(2'b01, 2'b01, 8'd255, 1, 0);
    total++; if (ovf_wait != 1) begin bad++; $display("FAIL minneg_ovf_held: got %0d want 1", ovf_wait); end
    total++; if (tr != "LXIA-XIA-") begin bad++; $display("FAIL minneg_trace: got %s want LXIA-XIA-", tr); end
    total++; if (div_log.size() != 2 || div_log[0] != 2 || div_log[1] != 3) begin
      bad++; $display("FAIL minneg_div_seq: got %p want 2 3", div_log);
    end
    total++; if (ovf_end != 0) begin bad++; $display("FAIL minneg_ovf_clear: got %0d want 0", ovf_end); end
  endtask

  task automatic test_start_hold;
    term_vec[0] = 17'sd3; nt = 1;
    // mode changes to 11 after the latch and start pulses during MULX1; both ignored
    run_eval(2'b01, 2'b11, 8'd8, 5, 1);
    total++; if (hold_bad != 0) begin bad++; $display("FAIL hold_wait_rel: got %0d bad cycles want 0", hold_bad); end
    total++; if (tr != "LXIA-") begin bad++; $display("FAIL hold_trace: got %s want LXIA-", tr); end
    @(negedge clk);
    total++; if (ready !== 1'b1 || ldx !== 1'b0) begin
      bad++; $display("FAIL hold_stays_idle: got ready=%b ldx=%b want 1/0", ready, ldx);
    end
  endtask

  task automatic test_reset_mid_divi;
    logic [9:0] s;
    int         n;
    term = 17'sd100;
    @(negedge clk);
    mode = 2'b00; y = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!i_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (!i_en) begin bad++; $display("FAIL rstmid_reach_divi: got i_en=%b want 1", i_en); end
    rst = 1'b1;
    @(negedge clk);
    s = {ldx, ldy, init_term, init_exp, x_en, ldterm, i_en, iplus_en, minus1_en, ldexp};
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready: got %b want 1", ready); end
    total++; if (s !== 10'b0) begin bad++; $display("FAIL rstmid_strobes: got %b want 0", s); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", ovf); end
    total++; if (div_i !== 5'd2) begin bad++; $display("FAIL rstmid_div_i: got %0d want 2", div_i); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1 || x_en !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle_after: got ready=%b x_en=%b want 1/0", ready, x_en);
    end
  endtask

  initial begin
    nt = 1;
    test_reset;
    test_step2;
    test_alt_step1;
    test_overflow;
    test_min_neg;
    test_start_hold;
    test_reset_mid_divi;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
